// File: rtl/mux_pipe_stage_if.sv
// Channel bus into and registered result out of mux_pipe_stage.
// Upstream drives in_bus/sel/in_valid; the stage drives out/out_sel/out_valid.
interface mux_pipe_stage_if #(
  parameter int N     = 32,
  parameter int CH    = 4,
  parameter int SEL_W = (CH > 1) ? $clog2(CH) : 1
);
  logic [CH*N-1:0]  in_bus;
  logic [SEL_W-1:0] sel;
  logic             in_valid;
  logic [N-1:0]     out;
  logic [SEL_W-1:0] out_sel;
  logic             out_valid;

  modport master (
    output in_bus, sel, in_valid,
    input  out, out_sel, out_valid
  );

  modport slave (
    input  in_bus, sel, in_valid,
    output out, out_sel, out_valid
  );
endinterface

// File: rtl/mux_pipe_stage.sv
// Registered CH:1 channel select with stall/flush, valid tracking, sticky
// out-of-range select flag and a saturating stall-cycle counter.
module mux_pipe_stage #(
  parameter int N     = 32,
  parameter int CH    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_pipe_stage_if.slave  bus,
  input  logic             stall,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic             sel_err,
  output logic [CNT_W-1:0] stall_cnt
);
  // The interface instance must be built with the same N and CH as this module.
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [SEL_W:0] CH_L = (SEL_W + 1)'(CH);

  // Valid semantics: in_valid marks a real instruction on in_bus/sel for this
  // cycle; out_valid marks out/out_sel as real. There is no ready: the stage
  // never back-pressures, stall/flush come from the hazard unit.

  logic [N-1:0]     w_mux;
  logic             w_sel_oob;
  logic             w_load;
  logic             w_cnt_inc;

  logic [N-1:0]     r_out;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_valid;
  logic             r_sel_err;
  logic [CNT_W-1:0] r_stall_cnt;

  always_comb begin
    w_sel_oob = ({1'b0, bus.sel} >= CH_L);
    w_mux     = bus.in_bus[(CH-1)*N +: N];
    for (int k = 0; k < CH; k++) begin
      if ({1'b0, bus.sel} == (SEL_W + 1)'(k)) begin
        w_mux = bus.in_bus[k*N +: N];
      end
    end
  end

  assign w_load    = !flush && !stall;
  assign w_cnt_inc = stall && !flush && r_out_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= bus.in_valid;
      // An invalid cycle leaves the data bits untouched to avoid toggling.
      if (bus.in_valid) begin
        r_out     <= w_mux;
        r_out_sel <= bus.sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_load && bus.in_valid && w_sel_oob) begin
      r_sel_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      r_stall_cnt <= '0;
    end else if (w_cnt_inc && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.out       = r_out;
  assign bus.out_sel   = r_out_sel;
  assign bus.out_valid = r_out_valid;
  assign sel_err       = r_sel_err;
  assign stall_cnt     = r_stall_cnt;
endmodule
